// File: rtl/fp_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared fp_unit. Holds one operation on the
// FPU for LAT+1 cycles, captures result and flags at a fixed count, returns them over valid/ready.
module fp_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  output logic        req0_rdy,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_vld,
  output logic        req1_rdy,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_vld,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_res,
  input  logic        fpu_exc,
  input  logic        fpu_ovf,
  input  logic        fpu_unf,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic [2:0]  sticky_flags,
  input  logic        flag_clr,
  output logic        busy
);

  localparam logic [2:0] LatCnt = 3'(LAT);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic        rr_q;
  logic        id_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  cnt_q;
  logic [31:0] data_q;
  logic [2:0]  flags_q;
  logic [2:0]  sticky_q;

  logic grant0, grant1, capture, handshake, in_exec;

  always_comb begin
    state_d   = state_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    in_exec   = (state_q == StExec);
    capture   = in_exec && (cnt_q == LatCnt);
    handshake = (state_q == StDone) && rsp_rdy;
    unique case (state_q)
      StIdle: begin
        // rst gating keeps rdy low while the arbiter is being cleared
        if (!rst) begin
          grant0 = req0_vld && (!rr_q || !req1_vld);
          grant1 = req1_vld && (rr_q || !req0_vld);
        end
        if (grant0 || grant1) state_d = StExec;
      end
      StExec:  if (capture) state_d = StDone;
      StDone:  if (handshake) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_q     <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      flags_q  <= '0;
      sticky_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        id_q  <= grant1;
        op_q  <= grant1 ? req1_op : req0_op;
        a_q   <= grant1 ? req1_a : req0_a;
        b_q   <= grant1 ? req1_b : req0_b;
        cnt_q <= '0;
      end else if (in_exec) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (capture) begin
        data_q  <= fpu_res;
        flags_q <= {fpu_exc, fpu_ovf, fpu_unf};
      end
      // A capture in the same cycle as a clear keeps only the new flags
      if (capture) begin
        sticky_q <= flag_clr ? {fpu_exc, fpu_ovf, fpu_unf}
                             : (sticky_q | {fpu_exc, fpu_ovf, fpu_unf});
      end else if (flag_clr) begin
        sticky_q <= '0;
      end
      if (handshake) rr_q <= ~id_q;
    end
  end

  assign req0_rdy     = grant0;
  assign req1_rdy     = grant1;
  assign fpu_op       = in_exec ? op_q : 2'b00;
  assign fpu_a        = in_exec ? a_q : 32'h0;
  assign fpu_b        = in_exec ? b_q : 32'h0;
  assign fpu_vld      = in_exec && (cnt_q == 3'd0);
  assign rsp_vld      = (state_q == StDone);
  assign rsp_id       = id_q;
  assign rsp_data     = data_q;
  assign rsp_flags    = flags_q;
  assign sticky_flags = sticky_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_fp_arbiter.sv
// Randomized scoreboard bench for fp_arbiter with a behavioural FPU stand-in that only returns
// the right answer when its operands were held for the full latency.
module tb_fp_arbiter;

  localparam int LAT = 2;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [2:0]  flags;
  } rsp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_vld, req0_rdy, req1_vld, req1_rdy;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  fpu_op;
  logic        fpu_vld;
  logic [31:0] fpu_a, fpu_b, fpu_res;
  logic        fpu_exc, fpu_ovf, fpu_unf;
  logic        rsp_vld, rsp_id;
  logic        rsp_rdy = 1'b0;
  logic        flag_clr = 1'b0;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags, sticky_flags;
  logic        busy;

  always #5 clk = ~clk;

  fp_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_op(req0_op), .req0_a(req0_a),
    .req0_b(req0_b),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_op(req1_op), .req1_a(req1_a),
    .req1_b(req1_b),
    .fpu_op(fpu_op), .fpu_vld(fpu_vld), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_res(fpu_res), .fpu_exc(fpu_exc), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .sticky_flags(sticky_flags), .flag_clr(flag_clr), .busy(busy)
  );

  // Reference FPU: known IEEE vectors, otherwise a deterministic scramble. Returns {flags, res}.
  function automatic logic [34:0] fpu_fn(input req_t r);
    logic [31:0] h;
    if (r.op == 2'd0 && r.a == 32'h3F800000 && r.b == 32'h40000000) return {3'b000, 32'h40400000};
    if (r.op == 2'd2 && r.a == 32'h40000000 && r.b == 32'h40400000) return {3'b000, 32'h40C00000};
    if (r.op == 2'd1 && r.a == 32'h40400000 && r.b == 32'h3F800000) return {3'b000, 32'h40000000};
    if (r.op == 2'd2 && r.a == 32'h7F000000 && r.b == 32'h7F000000) return {3'b010, 32'h7F800000};
    if (r.op == 2'd3) return {3'b000, r.a};
    h = (r.a * 32'd3) ^ {r.b[15:0], r.b[31:16]} ^ ({30'd0, r.op} * 32'h11111111);
    return {h[2:0] ^ r.a[31:29], h};
  endfunction

  // FPU stand-in: result valid LAT edges after presentation, garbage unless inputs were held.
  req_t        fpu_pipe [LAT];
  logic [34:0] fpu_out;
  always @(posedge clk) begin
    fpu_pipe[0] <= {fpu_op, fpu_a, fpu_b};
    for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  always_comb begin
    fpu_out = 35'h5_A5A5_A5A5;
    if (fpu_pipe[LAT-1] == {fpu_op, fpu_a, fpu_b}) fpu_out = fpu_fn(fpu_pipe[LAT-1]);
  end
  assign fpu_res = fpu_out[31:0];
  assign {fpu_exc, fpu_ovf, fpu_unf} = fpu_out[34:32];

  // Requester drivers
  logic pend [2];
  logic vld_r [2];
  req_t preq [2];
  req_t dir0 [$];
  req_t dir1 [$];
  assign req0_vld = vld_r[0];
  assign req1_vld = vld_r[1];
  assign {req0_op, req0_a, req0_b} = preq[0];
  assign {req1_op, req1_a, req1_b} = preq[1];

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q [$];

  // Reference model state
  int       k = 0;
  bit       m_busy = 0;
  int       m_acc_k = 0;
  bit       m_id = 0;
  bit       m_rr = 0;
  logic [2:0] m_nf = '0;
  logic [2:0] m_sticky = '0;
  bit       post_rst = 0;
  bit       did_rst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at iter %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic step(input bit gen, input bit rdy_lo, input bit rdy_hi, input bit do_rst);
    int   g;
    bit   m_done;
    rsp_t e;
    logic [34:0] r;
    @(negedge clk);
    rst = do_rst;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && gen) begin
        if (i == 0 && dir0.size() > 0) begin
          preq[i] = dir0.pop_front(); pend[i] = 1'b1;
        end else if (i == 1 && dir1.size() > 0) begin
          preq[i] = dir1.pop_front(); pend[i] = 1'b1;
        end else if ($urandom % 4 == 0) begin
          preq[i] = {2'($urandom), 32'($urandom), 32'($urandom)};
          pend[i] = 1'b1;
        end
      end
      vld_r[i] = pend[i] && ($urandom % 8 != 0);
    end
    rsp_rdy  = rdy_hi ? 1'b1 : (rdy_lo ? 1'b0 : 1'($urandom));
    flag_clr = ($urandom % 10 == 0);
    #1;
    if (post_rst) begin
      check("rst_fpu", {fpu_vld, fpu_op, fpu_a[28:0]}, 32'h0);
      check("rst_fpu_b", fpu_b, 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_misc", 32'({rsp_vld, rsp_id, rsp_flags, sticky_flags, busy}), 32'h0);
    end
    post_rst = do_rst;
    m_done = m_busy && (k >= m_acc_k + LAT + 2);
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_vld", 32'(rsp_vld), 32'(m_done));
    check("fpu_vld", 32'(fpu_vld), 32'(m_busy && k == m_acc_k + 1));
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
    g = -1;
    if (!do_rst && !m_busy) begin
      if (vld_r[m_rr]) g = int'(m_rr);
      else if (vld_r[!m_rr]) g = int'(!m_rr);
    end
    check("req0_rdy", 32'(req0_rdy), 32'(g == 0));
    check("req1_rdy", 32'(req1_rdy), 32'(g == 1));
    // Advance the model across the coming edge
    if (do_rst) begin
      m_busy = 0; m_rr = 0; m_sticky = '0;
      exp_q.delete();
    end else begin
      if (m_busy && k == m_acc_k + 1 + LAT) m_sticky = flag_clr ? m_nf : (m_sticky | m_nf);
      else if (flag_clr) m_sticky = '0;
      if (m_done && rsp_rdy) begin
        m_busy = 0; m_rr = !m_id;
      end
      if (g >= 0) begin
        r = fpu_fn(preq[g]);
        m_busy = 1; m_acc_k = k; m_id = (g == 1); m_nf = r[34:32];
        pend[g] = 1'b0;
        e = '{id: (g == 1), data: r[31:0], flags: r[34:32]};
        exp_q.push_back(e);
      end
    end
    k++;
  endtask

  // Monitor: pops the scoreboard on every response handshake
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got id %0d data %h, expected none", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", rsp_data, e.data);
          check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
        end
      end
    end
  end

  initial begin
    int  n;
    bit  dr;
    pend[0] = 1'b0; pend[1] = 1'b0;
    vld_r[0] = 1'b0; vld_r[1] = 1'b0;
    preq[0] = '0; preq[1] = '0;
    dir0.push_back('{op: 2'd0, a: 32'h3F800000, b: 32'h40000000});
    dir0.push_back('{op: 2'd2, a: 32'h7F000000, b: 32'h7F000000});
    dir0.push_back('{op: 2'd2, a: 32'h7F000000, b: 32'h7F000000});
    dir1.push_back('{op: 2'd2, a: 32'h40000000, b: 32'h40400000});
    dir1.push_back('{op: 2'd1, a: 32'h40400000, b: 32'h3F800000});
    for (int i = 0; i < 2000; i++) begin
      dr = (k < 3) || (!did_rst && k > 400 && m_busy && k == m_acc_k + 2);
      if (dr && k >= 3) did_rst = 1;
      step(1'b1, (k >= 200 && k < 215), 1'b0, dr);
    end
    n = 0;
    while ((pend[0] || pend[1] || m_busy) && n < 500) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_idle", 32'({pend[0], pend[1], busy}), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("reset_exercised", 32'(did_rst), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
